pipeline_hazard_ctrl: RTL

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 62 ++++++
 rtl/pipeline_hazard_ctrl_fwd_select.sv | 33 +++
 rtl/pipeline_hazard_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared core encodings: ALU/immediate/branch types plus the hazard-unit
// forwarding selects, next-PC selects and mul/div sequencer states.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [3:0] {
        ALUC_ADD  = 4'd0,
        ALUC_SUB  = 4'd1,
        ALUC_AND  = 4'd2,
        ALUC_OR   = 4'd3,
        ALUC_XOR  = 4'd4,
        ALUC_SLL  = 4'd5,
        ALUC_SRL  = 4'd6,
        ALUC_SRA  = 4'd7,
        ALUC_SLT  = 4'd8,
        ALUC_SLTU = 4'd9,
        ALUC_LUI  = 4'd10
    } aluc_t;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_type_t;

    typedef enum logic [2:0] {
        BT_EQ  = 3'd0,
        BT_NE  = 3'd1,
        BT_LT  = 3'd2,
        BT_GE  = 3'd3,
        BT_LTU = 3'd4,
        BT_GEU = 3'd5
    } b_type_t;

    // Operand source for the ID-stage read ports
    typedef enum logic [1:0] {
        QSEL_RF       = 2'd0,
        QSEL_EXE_ALU  = 2'd1,
        QSEL_MEM_ALU  = 2'd2,
        QSEL_MEM_LOAD = 2'd3
    } q_sel_t;

    // Next-PC source
    typedef enum logic [1:0] {
        PC_PLUS4  = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JAL    = 2'd2,
        PC_JALR   = 2'd3
    } pc_sel_t;

    // Mul/div stall sequencer
    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

    // Mul/div latency is at most 255, so an 8-bit down-counter suffices
    localparam int MD_CNT_W = 8;

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_select.sv
// Forwarding select for one ID-stage source operand. The EXE-stage ALU
// result is the youngest value, so it wins over anything sitting in MEM.
module fwd_select
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs,
    input  logic              use_rs,
    input  logic [REG_AW-1:0] erd,
    input  logic              ewreg,
    input  logic              em2reg,
    input  logic [REG_AW-1:0] mrd,
    input  logic              mwreg,
    input  logic              mm2reg,
    output q_sel_t            sel
);

    // Pick the youngest in-flight producer of rs; x0 and unused sources stay on the regfile
    always_comb begin
        sel = QSEL_RF;
        if (use_rs && (rs != '0)) begin
            if (ewreg && !em2reg && (erd == rs)) begin
                sel = QSEL_EXE_ALU;
            end else if (mwreg && !mm2reg && (mrd == rs)) begin
                sel = QSEL_MEM_ALU;
            end else if (mwreg && mm2reg && (mrd == rs)) begin
                sel = QSEL_MEM_LOAD;
            end
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline: operand forwarding, load-use
// stall, branch/jump redirect, mul/div stall sequencing and stall counters.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int MD_LAT = 34,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    input  logic              useRs1,
    input  logic              useRs2,
    input  logic [REG_AW-1:0] erd,
    input  logic [REG_AW-1:0] mrd,
    input  logic              ewreg,
    input  logic              mwreg,
    input  logic              em2reg,
    input  logic              mm2reg,
    input  logic              isBranch,
    input  logic              branchTaken,
    input  logic              isJal,
    input  logic              isJalr,
    input  logic              isMulDiv,
    output logic [1:0]        qaSel,
    output logic [1:0]        qbSel,
    output logic [1:0]        pcSel,
    output logic              pcStall,
    output logic              ifidStall,
    output logic              instNop,
    output logic              idexBubble,
    output logic              mdStart,
    output logic              mdBusy,
    output logic [CNT_W-1:0]  luStallCnt,
    output logic [CNT_W-1:0]  mdStallCnt
);

    q_sel_t              qa_sel;
    q_sel_t              qb_sel;
    pc_sel_t             pc_next;
    md_state_t           md_state;
    logic [MD_CNT_W-1:0] md_cnt;
    logic                lu_haz;
    logic                md_launch;
    logic                md_stall;
    logic                any_stall;

    fwd_select #(.REG_AW(REG_AW)) u_fwd_a (
        .rs     (rs1),
        .use_rs (useRs1),
        .erd    (erd),
        .ewreg  (ewreg),
        .em2reg (em2reg),
        .mrd    (mrd),
        .mwreg  (mwreg),
        .mm2reg (mm2reg),
        .sel    (qa_sel)
    );

    fwd_select #(.REG_AW(REG_AW)) u_fwd_b (
        .rs     (rs2),
        .use_rs (useRs2),
        .erd    (erd),
        .ewreg  (ewreg),
        .em2reg (em2reg),
        .mrd    (mrd),
        .mwreg  (mwreg),
        .mm2reg (mm2reg),
        .sel    (qb_sel)
    );

    // A load in EXE cannot forward yet; a mul/div only launches once that bubble is in
    assign lu_haz = ewreg && em2reg && (erd != '0) &&
                    ((useRs1 && (erd == rs1)) || (useRs2 && (erd == rs2)));
    assign md_launch = (md_state == MD_IDLE) && isMulDiv && !lu_haz;
    assign md_stall  = md_launch || (md_state == MD_BUSY);
    assign any_stall = md_stall || lu_haz;

    // Redirect only when the instruction in ID is actually allowed to proceed
    always_comb begin
        pc_next = PC_PLUS4;
        if (!any_stall) begin
            if (isJalr) begin
                pc_next = PC_JALR;
            end else if (isJal) begin
                pc_next = PC_JAL;
            end else if (isBranch && branchTaken) begin
                pc_next = PC_BRANCH;
            end
        end
    end

    // Reset forces every control output to its idle value and squashes ID
    assign qaSel      = rst ? QSEL_RF : qa_sel;
    assign qbSel      = rst ? QSEL_RF : qb_sel;
    assign pcSel      = rst ? PC_PLUS4 : pc_next;
    assign instNop    = rst || (pc_next != PC_PLUS4);
    assign pcStall    = !rst && any_stall;
    assign ifidStall  = !rst && any_stall;
    assign idexBubble = !rst && any_stall;
    assign mdStart    = !rst && md_launch;
    assign mdBusy     = !rst && (md_state != MD_IDLE);

    // Mul/div sequencer: launch cycle plus MD_LAT-1 BUSY cycles, then one stall-free DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            md_state <= MD_IDLE;
            md_cnt   <= '0;
        end else begin
            case (md_state)
                MD_IDLE: begin
                    if (md_launch) begin
                        md_state <= MD_BUSY;
                        md_cnt   <= MD_CNT_W'(MD_LAT - 1);
                    end
                end
                MD_BUSY: begin
                    md_cnt <= md_cnt - MD_CNT_W'(1);
                    if (md_cnt == MD_CNT_W'(1)) begin
                        md_state <= MD_DONE;
                    end
                end
                MD_DONE: begin
                    md_state <= MD_IDLE;
                end
                default: begin
                    md_state <= MD_IDLE;
                end
            endcase
        end
    end

    // Saturating stall-cycle counters
    always_ff @(posedge clk) begin
        if (rst) begin
            luStallCnt <= '0;
            mdStallCnt <= '0;
        end else begin
            if (lu_haz && (luStallCnt != '1)) begin
                luStallCnt <= luStallCnt + CNT_W'(1);
            end
            if (md_stall && (mdStallCnt != '1)) begin
                mdStallCnt <= mdStallCnt + CNT_W'(1);
            end
        end
    end

endmodule
